regfile_2r1w: RTL and testbench

- Parametrised register file built from the team's enable-gated register idea, generalised to DEPTH entries of WIDTH bits.
- Provides one write port and two independently enabled, registered read ports.
- Optional hardwired-zero entry 0.
- Sits between datapath control and the ALU as general operand storage. All state is cleared by the asynchronous active-low reset.

---
 rtl/regfile_2r1w.sv | 85 ++++++++
 tb/tb_regfile_2r1w.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// DEPTH x WIDTH register file, one write port and two enabled, registered read ports.
// Build option RF_BYPASS_EN: write-first forwarding from the write port to either read port.

module regfile_2r1w_cell #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)    q <= '0;
        else if (en) q <= d;
    end
endmodule

module regfile_2r1w #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b
);
    localparam int              SLOTS   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    // Every addressable slot exists; slots past DEPTH (and a hardwired entry 0) read as zero.
    logic [SLOTS-1:0][WIDTH-1:0] mem;
    logic                        wvalid;
    logic [WIDTH-1:0]            nxt_a, nxt_b;

    assign wvalid = we && ({1'b0, waddr} < DEPTH_L) && !(ZERO_REG != 0 && waddr == '0);

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);
        if (i < DEPTH && !(ZERO_REG != 0 && i == 0)) begin : g_cell
            logic wen;
            assign wen = wvalid && (waddr == IDX);
            regfile_2r1w_cell #(.WIDTH(WIDTH)) u_cell (
                .clk (clk),
                .clr (clr),
                .en  (wen),
                .d   (wdata),
                .q   (mem[i])
            );
        end else begin : g_zero
            assign mem[i] = '0;
        end
    end

`ifdef RF_BYPASS_EN
    always_comb begin
        nxt_a = mem[raddr_a];
        nxt_b = mem[raddr_b];
        if (wvalid && raddr_a == waddr) nxt_a = wdata;
        if (wvalid && raddr_b == waddr) nxt_b = wdata;
    end
`else
    assign nxt_a = mem[raddr_a];
    assign nxt_b = mem[raddr_b];
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (re_a) rdata_a <= nxt_a;
            if (re_b) rdata_b <= nxt_b;
        end
    end
endmodule

// File: tb/tb_regfile_2r1w.sv
// Drives three register-file builds (default, ZERO_REG=1, DEPTH=6) with shared stimulus
// and compares both read ports of each against an array-based reference.

module tb_regfile_2r1w;
    logic             clk = 1'b0;
    logic             clr;
    logic             we, re_a, re_b;
    logic [2:0]       waddr, raddr_a, raddr_b;
    logic [3:0]       wdata;
    logic [2:0][3:0]  rda, rdb;

    int errors = 0;
    int checks = 0;

    // Reference: per-build depth / zero-entry setting, contents and expected read data.
    int         dep [3] = '{8, 8, 6};
    bit         zr  [3] = '{0, 1, 0};
    logic [3:0] m   [3][8];
    logic [3:0] ea  [3];
    logic [3:0] eb  [3];

    always #5 clk = ~clk;

    regfile_2r1w #(.WIDTH(4), .DEPTH(8), .ADDR_W(3), .ZERO_REG(0)) u_dut0 (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rda[0]),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdb[0]));
    regfile_2r1w #(.WIDTH(4), .DEPTH(8), .ADDR_W(3), .ZERO_REG(1)) u_dut1 (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rda[1]),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdb[1]));
    regfile_2r1w #(.WIDTH(4), .DEPTH(6), .ADDR_W(3), .ZERO_REG(0)) u_dut2 (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rda[2]),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdb[2]));

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("%s cfg%0d A", tag, c), rda[c], ea[c]);
            chk($sformatf("%s cfg%0d B", tag, c), rdb[c], eb[c]);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 3; c++) begin
            for (int a = 0; a < 8; a++) m[c][a] = 4'h0;
            ea[c] = 4'h0;
            eb[c] = 4'h0;
        end
    endtask

    function automatic logic [3:0] ref_rd(int c, int a, bit wv, int wa, logic [3:0] wd);
        if (a >= dep[c] || (zr[c] && a == 0)) return 4'h0;
`ifdef RF_BYPASS_EN
        if (wv && a == wa) return wd;
`endif
        return m[c][a];
    endfunction

    // One clock: apply inputs, advance the reference at the edge, compare just after it.
    task automatic step(input string tag, input bit w, input int wa, input logic [3:0] wd,
                        input bit ra_en, input int ra, input bit rb_en, input int rb);
        we = w; waddr = 3'(wa); wdata = wd;
        re_a = ra_en; raddr_a = 3'(ra);
        re_b = rb_en; raddr_b = 3'(rb);
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            bit wv;
            wv = w && wa < dep[c] && !(zr[c] && wa == 0);
            if (ra_en) ea[c] = ref_rd(c, ra, wv, wa, wd);
            if (rb_en) eb[c] = ref_rd(c, rb, wv, wa, wd);
            if (wv) m[c][wa] = wd;
        end
        #1;
        chk_all(tag);
    endtask

    initial begin
        we = 0; waddr = 0; wdata = 0; re_a = 0; raddr_a = 0; re_b = 0; raddr_b = 0;
        clr = 1'b0;
        model_clear();
        #3;
        chk_all("reset");
        @(negedge clk);
        clr = 1'b1;
        #1;

        // Load 1..7 with nonzero data, read some back, then reset between edges.
        for (int a = 1; a < 8; a++) step("load", 1, a, 4'(a + 8), 0, 0, 0, 0);
        step("preread", 0, 0, 4'h0, 1, 3, 1, 5);
        chk("preread value", rda[0], 4'hB);
        #2;
        clr = 1'b0;
        #1;
        model_clear();
        chk_all("async reset");
        #1;
        clr = 1'b1;
        for (int a = 1; a < 8; a++) step("post reset read", 0, 0, 4'h0, 1, a, 1, 8 - a);

        // Latency and hold.
        step("write A", 1, 3, 4'hA, 0, 0, 0, 0);
        step("read A", 0, 0, 4'h0, 1, 3, 0, 0);
        chk("latency A", rda[0], 4'hA);
        step("hold A", 1, 3, 4'h2, 0, 1, 0, 0);
        chk("hold A", rda[0], 4'hA);

        // Dual port.
        step("write 5", 1, 2, 4'h5, 0, 0, 0, 0);
        step("write C", 1, 6, 4'hC, 0, 0, 0, 0);
        step("dual", 0, 0, 4'h0, 1, 2, 1, 6);
        chk("dual A", rda[0], 4'h5);
        chk("dual B", rdb[0], 4'hC);
        chk("dual B oob", rdb[2], 4'h0);
        step("same addr", 0, 0, 4'h0, 1, 6, 1, 6);
        chk("same addr A", rda[0], 4'hC);
        chk("same addr B", rdb[0], 4'hC);

        // Write/read collision.
        step("write 1", 1, 5, 4'h1, 0, 0, 0, 0);
        step("collide", 1, 5, 4'h9, 1, 5, 0, 0);
`ifdef RF_BYPASS_EN
        chk("collide fwd", rda[0], 4'h9);
`else
        chk("collide old", rda[0], 4'h1);
`endif
        step("after collide", 0, 0, 4'h0, 1, 5, 0, 0);
        chk("after collide", rda[0], 4'h9);

        // Entry 0: hardwired in cfg1, ordinary elsewhere.
        step("write 0", 1, 0, 4'hF, 0, 0, 0, 0);
        step("read 0", 0, 0, 4'h0, 1, 0, 1, 0);
        chk("zero reg", rda[1], 4'h0);
        chk("plain reg0", rda[0], 4'hF);
        step("collide 0", 1, 0, 4'h3, 1, 0, 1, 0);
        chk("zero reg collide", rdb[1], 4'h0);

        // Out-of-range writes and reads.
        step("write oob 6", 1, 6, 4'h7, 0, 0, 0, 0);
        step("write oob 7", 1, 7, 4'h7, 0, 0, 0, 0);
        for (int a = 0; a < 8; a++) step("oob sweep", 0, 0, 4'h0, 1, a, 1, 7 - a);
        step("oob 6 read", 0, 0, 4'h0, 1, 6, 1, 7);
        chk("oob 6 cfg2", rda[2], 4'h0);
        chk("oob 7 cfg2", rdb[2], 4'h0);

        // Random traffic.
        for (int n = 0; n < 400; n++)
            step("random", bit'($urandom_range(0, 1)), $urandom_range(0, 7), 4'($urandom),
                 bit'($urandom_range(0, 1)), $urandom_range(0, 7),
                 bit'($urandom_range(0, 1)), $urandom_range(0, 7));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
